// File: rtl/cpu_pkg.sv
// Shared CPU datapath constants, word/index types and write-back select encoding.
// Used by the write-back stage and the EX-stage forwarding path.
package cpu_pkg;

    localparam int DW        = 32;
    localparam int NREG      = 64;
    localparam int REG_IDX_W = 6;

    typedef logic [DW-1:0]        word_t;
    typedef logic [REG_IDX_W-1:0] reg_idx_t;

    typedef enum logic [1:0] {
        WBSEL_ALU = 2'd0,
        WBSEL_MEM = 2'd1,
        WBSEL_PC  = 2'd2
    } wbsel_t;

    // Save-PC wins over a load so call-type instructions always link correctly.
    function automatic wbsel_t wbsel_decode(input logic svpc, input logic mem_to_reg);
        if (svpc) begin
            return WBSEL_PC;
        end
        if (mem_to_reg) begin
            return WBSEL_MEM;
        end
        return WBSEL_ALU;
    endfunction

endpackage

// File: rtl/wb_mux.sv
// 3:1 write-back value select (ALU / load data / PC+1) with save-PC priority.
// Purely combinational; shared with the EX-stage forwarding path.
module wb_mux
    import cpu_pkg::*;
#(
    parameter int W = DW
) (
    input  logic         svpc_i,
    input  logic         mem_to_reg_i,
    input  logic [W-1:0] alu_i,
    input  logic [W-1:0] mem_i,
    input  logic [W-1:0] pc_i,
    output logic [W-1:0] wb_o
);

    always_comb begin
        wb_o = alu_i;
        case (wbsel_decode(svpc_i, mem_to_reg_i))
            WBSEL_MEM: wb_o = mem_i;
            WBSEL_PC:  wb_o = pc_i;
            default:   wb_o = alu_i;
        endcase
    end

endmodule

// File: rtl/wb_regfile.sv
// Write-back stage: selects the write-back value, commits it to the register file,
// serves two async read ports and keeps debug write tracking. Option: WB_BYPASS_EN.
module wb_regfile #(
    parameter int NREG    = cpu_pkg::NREG,
    parameter int DW      = cpu_pkg::DW,
    parameter int R0_ZERO = 1
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          memToReg,
    input  logic [DW-1:0]                 dataMem,
    input  logic [DW-1:0]                 ALU,
    input  logic                          regWrt,
    input  logic [cpu_pkg::REG_IDX_W-1:0] rd,
    input  logic [DW-1:0]                 adder,
    input  logic                          svpc,
    input  logic [cpu_pkg::REG_IDX_W-1:0] rs,
    input  logic [cpu_pkg::REG_IDX_W-1:0] rt,
    output logic [DW-1:0]                 rsData,
    output logic [DW-1:0]                 rtData,
    output logic [DW-1:0]                 wbData,
    output logic [31:0]                   wbCount,
    output logic [cpu_pkg::REG_IDX_W-1:0] lastRd,
    output logic [DW-1:0]                 lastData
);

    import cpu_pkg::*;

    logic [DW-1:0] regs_q [NREG];
    logic [DW-1:0] wb_data;
    logic          wr_en;
    logic          r0_hard;

    logic [31:0]   wb_count_q, wb_count_d;
    reg_idx_t      last_rd_q, last_rd_d;
    logic [DW-1:0] last_data_q, last_data_d;

    wb_mux #(
        .W(DW)
    ) u_wb_mux (
        .svpc_i      (svpc),
        .mem_to_reg_i(memToReg),
        .alu_i       (ALU),
        .mem_i       (dataMem),
        .pc_i        (adder),
        .wb_o        (wb_data)
    );

    assign r0_hard = (R0_ZERO != 0);
    assign wr_en   = regWrt && !(r0_hard && (rd == '0));

    always_comb begin
        wb_count_d  = wb_count_q;
        last_rd_d   = last_rd_q;
        last_data_d = last_data_q;
        if (wr_en) begin
            wb_count_d  = wb_count_q + 32'd1;
            last_rd_d   = rd;
            last_data_d = wb_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NREG; i++) begin
                regs_q[i] <= '0;
            end
            wb_count_q  <= '0;
            last_rd_q   <= '0;
            last_data_q <= '0;
        end else begin
            if (wr_en) begin
                regs_q[rd] <= wb_data;
            end
            wb_count_q  <= wb_count_d;
            last_rd_q   <= last_rd_d;
            last_data_q <= last_data_d;
        end
    end

    // Discarded r0 writes never set wr_en, so r0 is never bypassed either.
    always_comb begin
        rsData = regs_q[rs];
        if (r0_hard && (rs == '0)) begin
            rsData = '0;
        end
`ifdef WB_BYPASS_EN
        if (wr_en && (rd == rs)) begin
            rsData = wb_data;
        end
`endif
    end

    always_comb begin
        rtData = regs_q[rt];
        if (r0_hard && (rt == '0)) begin
            rtData = '0;
        end
`ifdef WB_BYPASS_EN
        if (wr_en && (rd == rt)) begin
            rtData = wb_data;
        end
`endif
    end

    assign wbData   = wb_data;
    assign wbCount  = wb_count_q;
    assign lastRd   = last_rd_q;
    assign lastData = last_data_q;

endmodule

// File: tb/tb_wb_regfile.sv
// Self-checking bench for wb_regfile: vector table, directed corner sequences
// and randomized traffic against an array-based reference model.
module tb_wb_regfile;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        memToReg, regWrt, svpc;
    logic [31:0] dataMem, ALU, adder;
    logic [5:0]  rd, rs, rt;
    logic [31:0] rsData, rtData, wbData, wbCount, lastData;
    logic [5:0]  lastRd;

    wb_regfile dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .memToReg(memToReg),
        .dataMem (dataMem),
        .ALU     (ALU),
        .regWrt  (regWrt),
        .rd      (rd),
        .adder   (adder),
        .svpc    (svpc),
        .rs      (rs),
        .rt      (rt),
        .rsData  (rsData),
        .rtData  (rtData),
        .wbData  (wbData),
        .wbCount (wbCount),
        .lastRd  (lastRd),
        .lastData(lastData)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;

    logic [31:0] m_regs [64];
    logic [31:0] m_count;
    logic [5:0]  m_last_rd;
    logic [31:0] m_last_data;

    function automatic logic [31:0] m_wb();
        return svpc ? adder : (memToReg ? dataMem : ALU);
    endfunction

    function automatic logic [31:0] m_read(input logic [5:0] idx);
        if (idx == 6'd0) return 32'd0;
`ifdef WB_BYPASS_EN
        if (regWrt && rd == idx) return m_wb();
`endif
        return m_regs[idx];
    endfunction

    task automatic m_reset();
        for (int i = 0; i < 64; i++) m_regs[i] = 32'd0;
        m_count     = 32'd0;
        m_last_rd   = 6'd0;
        m_last_data = 32'd0;
    endtask

    task automatic m_commit();
        if (rst_n && regWrt && rd != 6'd0) begin
            m_regs[rd]  = m_wb();
            m_count     = m_count + 32'd1;
            m_last_rd   = rd;
            m_last_data = m_wb();
        end
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %08h expected %08h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        m_commit();
        #1;
    endtask

    task automatic check_state(input string tag);
        chk({tag, ".wbCount"}, wbCount, m_count);
        chk({tag, ".lastRd"}, 32'(lastRd), 32'(m_last_rd));
        chk({tag, ".lastData"}, lastData, m_last_data);
    endtask

    task automatic drive(input logic w, input logic [5:0] d, input logic m2r, input logic sv,
                         input logic [31:0] a, input logic [31:0] dm, input logic [31:0] ad);
        regWrt = w; rd = d; memToReg = m2r; svpc = sv;
        ALU = a; dataMem = dm; adder = ad;
    endtask

    typedef struct {
        logic        m2r;
        logic        sv;
        logic [5:0]  rd;
        logic [31:0] alu;
        logic [31:0] dm;
        logic [31:0] ad;
        logic [31:0] exp;
    } vec_t;

    vec_t vt [6];

    initial begin
        logic [31:0] saved_count, exp_raw;
        logic [5:0]  saved_rd;
        logic [31:0] saved_data;

        vt[0] = '{1'b0, 1'b0, 6'd3,  32'h11,   32'h22,   32'h33,   32'h11};
        vt[1] = '{1'b1, 1'b0, 6'd3,  32'h11,   32'h22,   32'h33,   32'h22};
        vt[2] = '{1'b1, 1'b1, 6'd3,  32'h11,   32'h22,   32'h33,   32'h33};
        vt[3] = '{1'b0, 1'b1, 6'd4,  32'hA1,   32'hA2,   32'hA3,   32'hA3};
        vt[4] = '{1'b0, 1'b0, 6'd63, 32'h1234, 32'h5555, 32'h6666, 32'h1234};
        vt[5] = '{1'b1, 1'b0, 6'd40, 32'h0BAD, 32'hF00D, 32'h0001, 32'hF00D};

        rst_n = 1'b1;
        drive(1'b0, 6'd0, 1'b0, 1'b0, 32'd0, 32'd0, 32'd0);
        rs = 6'd0; rt = 6'd0;
        #3 rst_n = 1'b0;
        m_reset();
        #1;
        check_state("reset0");
        for (int i = 0; i < 64; i += 9) begin
            rs = 6'(i); #1;
            chk("reset0.read", rsData, 32'd0);
        end
        @(negedge clk) rst_n = 1'b1;
        tick();

        // Vector table: write-back select, commit, counter and capture
        for (int i = 0; i < 6; i++) begin
            drive(1'b1, vt[i].rd, vt[i].m2r, vt[i].sv, vt[i].alu, vt[i].dm, vt[i].ad);
            rs = vt[i].rd; rt = vt[i].rd;
            #1;
            chk("vec.wbData", wbData, vt[i].exp);
            chk("vec.pre_read", rsData, m_read(rs));
            tick();
            chk("vec.rsData", rsData, vt[i].exp);
            chk("vec.rtData", rtData, vt[i].exp);
            chk("vec.wbCount", wbCount, 32'(i + 1));
            chk("vec.lastRd", 32'(lastRd), 32'(vt[i].rd));
            chk("vec.lastData", lastData, vt[i].exp);
        end

        // r0 writes discarded
        drive(1'b1, 6'd0, 1'b0, 1'b0, 32'hDEADBEEF, 32'd0, 32'd0);
        rs = 6'd0; rt = 6'd0;
        #1;
        chk("r0.pre_read", rsData, 32'd0);
        tick();
        chk("r0.read", rsData, 32'd0);
        chk("r0.wbCount", wbCount, 32'd6);
        chk("r0.lastRd", 32'(lastRd), 32'd40);
        chk("r0.lastData", lastData, 32'hF00D);

        // Same-cycle read-after-write on r63
        drive(1'b1, 6'd63, 1'b0, 1'b0, 32'hCAFEF00D, 32'd0, 32'd0);
        rs = 6'd63;
        #1;
`ifdef WB_BYPASS_EN
        exp_raw = 32'hCAFEF00D;
`else
        exp_raw = 32'h1234;
`endif
        chk("raw.same_cycle", rsData, exp_raw);
        tick();
        chk("raw.after_edge", rsData, 32'hCAFEF00D);

        // Dual read of r7, then idle cycles leave state untouched
        drive(1'b1, 6'd7, 1'b0, 1'b0, 32'h5, 32'd0, 32'd0);
        tick();
        regWrt = 1'b0; rs = 6'd7; rt = 6'd7;
        #1;
        chk("dual.rs", rsData, 32'h5);
        chk("dual.rt", rtData, 32'h5);
        saved_count = m_count; saved_rd = m_last_rd; saved_data = m_last_data;
        for (int i = 0; i < 10; i++) begin
            drive(1'b0, 6'($urandom), 1'($urandom), 1'($urandom), $urandom, $urandom, $urandom);
            tick();
            chk("idle.rs", rsData, 32'h5);
            chk("idle.rt", rtData, 32'h5);
            chk("idle.wbCount", wbCount, saved_count);
            chk("idle.lastRd", 32'(lastRd), 32'(saved_rd));
            chk("idle.lastData", lastData, saved_data);
        end

        // Counter wrap
        drive(1'b0, 6'd0, 1'b0, 1'b0, 32'd0, 32'd0, 32'd0);
        force dut.wb_count_q = 32'hFFFF_FFFE;
        #1;
        release dut.wb_count_q;
        #1;
        m_count = 32'hFFFF_FFFE;
        chk("wrap.preset", wbCount, 32'hFFFF_FFFE);
        drive(1'b1, 6'd10, 1'b0, 1'b0, 32'h1010, 32'h9999, 32'h8888);
        tick();
        chk("wrap.count1", wbCount, 32'hFFFF_FFFF);
        chk("wrap.lastRd1", 32'(lastRd), 32'd10);
        chk("wrap.lastData1", lastData, 32'h1010);
        drive(1'b1, 6'd11, 1'b1, 1'b0, 32'h7777, 32'h2020, 32'h8888);
        tick();
        chk("wrap.count2", wbCount, 32'h0);
        chk("wrap.lastRd2", 32'(lastRd), 32'd11);
        chk("wrap.lastData2", lastData, 32'h2020);

        // Randomized traffic against the model
        for (int n = 0; n < 400; n++) begin
            regWrt   = ($urandom_range(0, 3) != 0);
            rd       = ($urandom_range(0, 7) == 0) ? 6'd0 : 6'($urandom);
            memToReg = 1'($urandom);
            svpc     = 1'($urandom);
            ALU      = $urandom;
            dataMem  = $urandom;
            adder    = $urandom;
            rs       = ($urandom_range(0, 3) == 0) ? rd : 6'($urandom);
            rt       = ($urandom_range(0, 3) == 0) ? rd : 6'($urandom);
            #1;
            chk("rnd.wbData", wbData, m_wb());
            chk("rnd.pre_rs", rsData, m_read(rs));
            chk("rnd.pre_rt", rtData, m_read(rt));
            tick();
            chk("rnd.post_rs", rsData, m_read(rs));
            chk("rnd.post_rt", rtData, m_read(rt));
            check_state("rnd");
        end

        // Reset asserted mid-cycle while a write to r5 is pending
        drive(1'b1, 6'd5, 1'b0, 1'b0, 32'h77, 32'd0, 32'd0);
        #2 rst_n = 1'b0;
        m_reset();
        #1;
        check_state("midrst");
        for (int i = 0; i < 64; i++) begin
            rs = 6'(i); #1;
            chk("midrst.read", rsData, m_read(rs));
        end
        tick();
        regWrt = 1'b0; rs = 6'd5;
        #1;
        chk("midrst.r5_held", rsData, 32'd0);
        chk("midrst.count_held", wbCount, 32'd0);
        regWrt = 1'b1;
        @(negedge clk) rst_n = 1'b1;
        tick();
        chk("postrst.r5", rsData, 32'h77);
        chk("postrst.wbCount", wbCount, 32'd1);
        chk("postrst.lastRd", 32'(lastRd), 32'd5);
        chk("postrst.lastData", lastData, 32'h77);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
